make_go_fast_hls_deadlock_detect_unit_filt: RTL and testbench

Per-process deadlock detection node for the make_go_fast HLS dataflow region, one instance per process and ring-connected to its neighbours through dependence channels. It merges incoming dependence vectors, forwards its own vector downstream and passes the report token. It declares a deadlock only after its own process ID has stayed in the merged dependence set for a parametrised number of consecutive cycles. On confirmation it freezes a snapshot of the dependence set, holds a sticky report until software clears it, and counts reports.

---
 rtl/make_go_fast_hls_dl_pkg.sv | 17 +
 rtl/make_go_fast_hls_dl_dep_merge.sv | 18 +
 rtl/make_go_fast_hls_deadlock_detect_unit_filt.sv | 120 ++++++++++++
 tb/tb_make_go_fast_hls_deadlock_detect_unit_filt.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/make_go_fast_hls_dl_pkg.sv
// Shared definitions for the make_go_fast HLS deadlock detection nodes.
package make_go_fast_hls_dl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUSPECT = 2'd1,
        REPORT  = 2'd2
    } dl_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/make_go_fast_hls_dl_dep_merge.sv
// Masked OR-reduce of the incoming dependence vectors; invalid channels contribute nothing.
module make_go_fast_hls_dl_dep_merge #(
    parameter int PROC_NUM    = 4,
    parameter int IN_CHAN_NUM = 2
) (
    input  logic [IN_CHAN_NUM-1:0]          chan_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] chan_data_vec,
    output logic [PROC_NUM-1:0]             merged
);

    always_comb begin
        merged = '0;
        for (int i = 0; i < IN_CHAN_NUM; i++) begin
            if (chan_vld_vec[i]) merged = merged | chan_data_vec[i*PROC_NUM +: PROC_NUM];
        end
    end

endmodule

// File: rtl/make_go_fast_hls_deadlock_detect_unit_filt.sv
// Per-process deadlock detection node: merges upstream dependences, confirms a
// self-dependence over CONFIRM_CYCLES consecutive cycles, then holds a sticky report.
//
// state   | meaning
// IDLE    | no self-dependence seen on the last edge
// SUSPECT | self-dependence seen on cnt consecutive edges, not yet confirmed
// REPORT  | deadlock confirmed; held until clear_sticky
module make_go_fast_hls_deadlock_detect_unit_filt
    import make_go_fast_hls_dl_pkg::*;
#(
    parameter int PROC_NUM       = 4,
    parameter int PROC_ID        = 0,
    parameter int IN_CHAN_NUM    = 2,
    parameter int OUT_CHAN_NUM   = 3,
    parameter int CONFIRM_CYCLES = 4,
    parameter int RPT_CNT_W      = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
    input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
    input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
    input  logic                            dl_detect_in,
    input  logic                            origin,
    input  logic                            token_clear,
    input  logic                            clear_sticky,
    output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
    output logic [PROC_NUM-1:0]             out_chan_dep_data,
    output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
    output logic                            dl_detect_out,
    output logic [PROC_NUM-1:0]             dl_dep_snapshot,
    output logic [RPT_CNT_W-1:0]            dl_rpt_cnt
);

    localparam int CNT_W = clog2(CONFIRM_CYCLES + 1);
    localparam logic [PROC_NUM-1:0] SELF_BIT = PROC_NUM'(1) << PROC_ID;

    dl_state_e             state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt, cnt_inc;
    logic [PROC_NUM-1:0]   dep_reg, dep_next, merged;
    logic                  live, blocked, self_dep, enter_report, token_go;

    make_go_fast_hls_dl_dep_merge #(
        .PROC_NUM    (PROC_NUM),
        .IN_CHAN_NUM (IN_CHAN_NUM)
    ) u_dep_merge (
        .chan_vld_vec  (in_chan_dep_vld_vec),
        .chan_data_vec (in_chan_dep_data_vec),
        .merged        (merged)
    );

    // Once a deadlock is globally known, only token holders keep refreshing dependences.
    assign live     = ~dl_detect_in | (|token_in_vec);
    assign blocked  = |proc_dep_vld_vec;
    assign dep_next = live ? merged : dep_reg;
    assign self_dep = live & dep_next[PROC_ID] & blocked;
    assign token_go = ((|token_in_vec) & ~token_clear) | origin;
    assign cnt_inc  = cnt + CNT_W'(1);

    assign out_chan_dep_vld_vec = proc_dep_vld_vec;
    assign out_chan_dep_data    = dep_reg | SELF_BIT;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (self_dep) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = (CONFIRM_CYCLES == 1) ? REPORT : SUSPECT;
                end
            end
            SUSPECT: begin
                if (self_dep) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_W'(CONFIRM_CYCLES)) state_nxt = REPORT;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            REPORT: begin
                if (clear_sticky) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign enter_report = (state != REPORT) && (state_nxt == REPORT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            dep_reg         <= '0;
            token_out_vec   <= '0;
            dl_detect_out   <= 1'b0;
            dl_dep_snapshot <= '0;
            dl_rpt_cnt      <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            dep_reg       <= blocked ? dep_next : '0;
            token_out_vec <= token_go ? proc_dep_vld_vec : '0;
            dl_detect_out <= (state_nxt == REPORT);
            if (enter_report) begin
                dl_dep_snapshot <= dep_next;
                if (dl_rpt_cnt != '1) dl_rpt_cnt <= dl_rpt_cnt + RPT_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_make_go_fast_hls_deadlock_detect_unit_filt.sv
// Directed and randomized checks of the deadlock detection node against a cycle-level model.
module tb_make_go_fast_hls_deadlock_detect_unit_filt;

    localparam int PN  = 4;
    localparam int PID = 1;
    localparam int ICN = 2;
    localparam int OCN = 3;
    localparam int CC  = 3;
    localparam int RW  = 2;
    localparam int CNT_MAX = 3;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [OCN-1:0]  proc_dep_vld_vec = '0;
    logic [ICN-1:0]  in_chan_dep_vld_vec = '0;
    logic [ICN*PN-1:0] in_chan_dep_data_vec = '0;
    logic [ICN-1:0]  token_in_vec = '0;
    logic            dl_detect_in = 1'b0;
    logic            origin = 1'b0;
    logic            token_clear = 1'b0;
    logic            clear_sticky = 1'b0;
    logic [OCN-1:0]  out_chan_dep_vld_vec;
    logic [PN-1:0]   out_chan_dep_data;
    logic [OCN-1:0]  token_out_vec;
    logic            dl_detect_out;
    logic [PN-1:0]   dl_dep_snapshot;
    logic [RW-1:0]   dl_rpt_cnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [PN-1:0]  m_dep;
    logic [PN-1:0]  m_snap;
    logic [OCN-1:0] m_tok;
    int             m_run;
    int             m_cnt;
    bit             m_rep;

    make_go_fast_hls_deadlock_detect_unit_filt #(
        .PROC_NUM(PN), .PROC_ID(PID), .IN_CHAN_NUM(ICN), .OUT_CHAN_NUM(OCN),
        .CONFIRM_CYCLES(CC), .RPT_CNT_W(RW)
    ) dut (
        .clock(clock), .reset(reset),
        .proc_dep_vld_vec(proc_dep_vld_vec),
        .in_chan_dep_vld_vec(in_chan_dep_vld_vec),
        .in_chan_dep_data_vec(in_chan_dep_data_vec),
        .token_in_vec(token_in_vec),
        .dl_detect_in(dl_detect_in),
        .origin(origin),
        .token_clear(token_clear),
        .clear_sticky(clear_sticky),
        .out_chan_dep_vld_vec(out_chan_dep_vld_vec),
        .out_chan_dep_data(out_chan_dep_data),
        .token_out_vec(token_out_vec),
        .dl_detect_out(dl_detect_out),
        .dl_dep_snapshot(dl_dep_snapshot),
        .dl_rpt_cnt(dl_rpt_cnt)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_dep = '0; m_snap = '0; m_tok = '0; m_run = 0; m_cnt = 0; m_rep = 0;
    endtask

    task automatic set_in(input logic [OCN-1:0] pdv, input logic [ICN-1:0] vld,
                          input logic [ICN*PN-1:0] data, input logic [ICN-1:0] tok,
                          input logic dli, input logic org, input logic tclr, input logic clr);
        proc_dep_vld_vec = pdv; in_chan_dep_vld_vec = vld; in_chan_dep_data_vec = data;
        token_in_vec = tok; dl_detect_in = dli; origin = org; token_clear = tclr;
        clear_sticky = clr;
    endtask

    // One clock edge; the model consumes the inputs that were present at the edge.
    task automatic cycle();
        logic [PN-1:0] merged, dn;
        bit live, sd;
        @(posedge clock);
        merged = '0;
        for (int i = 0; i < ICN; i++)
            if (in_chan_dep_vld_vec[i]) merged |= in_chan_dep_data_vec[i*PN +: PN];
        live = !dl_detect_in || (token_in_vec != 0);
        dn = live ? merged : m_dep;
        sd = live && dn[PID] && (proc_dep_vld_vec != 0);
        if (m_rep) begin
            if (clear_sticky) begin m_rep = 0; m_run = 0; end
        end else if (sd) begin
            m_run++;
            if (m_run >= CC) begin
                m_rep = 1; m_run = 0; m_snap = dn;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end else begin
            m_run = 0;
        end
        m_dep = (proc_dep_vld_vec != 0) ? dn : '0;
        m_tok = (((token_in_vec != 0) && !token_clear) || origin) ? proc_dep_vld_vec : '0;
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        checks++; if (dl_detect_out !== 1'b0) begin errors++; $display("FAIL reset_detect got=%0h want=0", dl_detect_out); end
        checks++; if (token_out_vec !== 3'b000) begin errors++; $display("FAIL reset_token got=%0h want=0", token_out_vec); end
        checks++; if (dl_dep_snapshot !== 4'b0000) begin errors++; $display("FAIL reset_snap got=%0h want=0", dl_dep_snapshot); end
        checks++; if (dl_rpt_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0h want=0", dl_rpt_cnt); end
        checks++; if (out_chan_dep_data !== 4'b0010) begin errors++; $display("FAIL reset_depdata got=%0h want=2", out_chan_dep_data); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_confirmed();
        set_in(3'b001, 2'b01, 8'h06, 2'b00, 0, 0, 0, 0);
        for (int c = 1; c <= CC; c++) begin
            cycle();
            checks++;
            if (dl_detect_out !== (c == CC)) begin
                errors++; $display("FAIL confirm_detect cyc=%0d got=%0h want=%0h", c, dl_detect_out, (c == CC));
            end
        end
        checks++; if (dl_dep_snapshot !== 4'b0110) begin errors++; $display("FAIL confirm_snap got=%0h want=6", dl_dep_snapshot); end
        checks++; if (dl_rpt_cnt !== 2'd1) begin errors++; $display("FAIL confirm_cnt got=%0h want=1", dl_rpt_cnt); end
        checks++; if (out_chan_dep_data !== 4'b0110) begin errors++; $display("FAIL confirm_depdata got=%0h want=6", out_chan_dep_data); end
    endtask

    task automatic test_clear_rearm();
        clear_sticky = 1'b1;
        cycle();
        clear_sticky = 1'b0;
        checks++; if (dl_detect_out !== 1'b0) begin errors++; $display("FAIL clear_detect got=%0h want=0", dl_detect_out); end
        for (int c = 1; c <= CC; c++) begin
            cycle();
            checks++;
            if (dl_detect_out !== (c == CC)) begin
                errors++; $display("FAIL rearm_detect cyc=%0d got=%0h want=%0h", c, dl_detect_out, (c == CC));
            end
        end
        checks++; if (dl_rpt_cnt !== 2'd2) begin errors++; $display("FAIL rearm_cnt got=%0h want=2", dl_rpt_cnt); end
        set_in(3'b000, 2'b00, 8'h00, 2'b00, 0, 0, 0, 1);
        cycle();
        clear_sticky = 1'b0;
        checks++; if (dl_detect_out !== 1'b0) begin errors++; $display("FAIL clear_idle got=%0h want=0", dl_detect_out); end
    endtask

    task automatic test_broken_run();
        for (int c = 0; c < 5; c++) begin
            if (c == 2) set_in(3'b001, 2'b00, 8'h06, 2'b00, 0, 0, 0, 0);
            else        set_in(3'b001, 2'b01, 8'h06, 2'b00, 0, 0, 0, 0);
            cycle();
            checks++; if (dl_detect_out !== 1'b0) begin errors++; $display("FAIL broken_detect cyc=%0d got=%0h want=0", c, dl_detect_out); end
        end
        set_in(3'b000, 2'b00, 8'h00, 2'b00, 0, 0, 0, 0);
        cycle();
    endtask

    task automatic test_gating();
        set_in(3'b001, 2'b01, 8'h04, 2'b00, 0, 0, 0, 0);
        cycle();
        checks++; if (out_chan_dep_data !== 4'b0110) begin errors++; $display("FAIL gate_seed got=%0h want=6", out_chan_dep_data); end
        set_in(3'b001, 2'b01, 8'h02, 2'b00, 1, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            cycle();
            checks++; if (out_chan_dep_data !== 4'b0110) begin errors++; $display("FAIL gate_hold cyc=%0d got=%0h want=6", c, out_chan_dep_data); end
            checks++; if (dl_detect_out !== 1'b0) begin errors++; $display("FAIL gate_nocount cyc=%0d got=%0h want=0", c, dl_detect_out); end
        end
        token_in_vec = 2'b01;
        for (int c = 1; c <= CC; c++) begin
            cycle();
            checks++;
            if (dl_detect_out !== (c == CC)) begin
                errors++; $display("FAIL gate_count cyc=%0d got=%0h want=%0h", c, dl_detect_out, (c == CC));
            end
        end
        checks++; if (dl_dep_snapshot !== 4'b0010) begin errors++; $display("FAIL gate_snap got=%0h want=2", dl_dep_snapshot); end
        checks++; if (dl_rpt_cnt !== 2'd3) begin errors++; $display("FAIL gate_cnt got=%0h want=3", dl_rpt_cnt); end
        set_in(3'b000, 2'b00, 8'h00, 2'b00, 0, 0, 0, 1);
        cycle();
    endtask

    task automatic test_token();
        set_in(3'b101, 2'b00, 8'h00, 2'b10, 0, 0, 0, 0);
        #1;
        checks++; if (out_chan_dep_vld_vec !== 3'b101) begin errors++; $display("FAIL tok_vld_comb got=%0h want=5", out_chan_dep_vld_vec); end
        checks++; if (token_out_vec !== 3'b000) begin errors++; $display("FAIL tok_latency got=%0h want=0", token_out_vec); end
        cycle();
        checks++; if (token_out_vec !== 3'b101) begin errors++; $display("FAIL tok_pass got=%0h want=5", token_out_vec); end
        token_clear = 1'b1;
        cycle();
        checks++; if (token_out_vec !== 3'b000) begin errors++; $display("FAIL tok_clear got=%0h want=0", token_out_vec); end
        origin = 1'b1;
        cycle();
        checks++; if (token_out_vec !== 3'b101) begin errors++; $display("FAIL tok_origin got=%0h want=5", token_out_vec); end
        set_in(3'b000, 2'b00, 8'h00, 2'b00, 0, 0, 0, 0);
        cycle();
        checks++; if (token_out_vec !== 3'b000) begin errors++; $display("FAIL tok_idle got=%0h want=0", token_out_vec); end
    endtask

    task automatic test_saturate();
        for (int r = 0; r < 3; r++) begin
            set_in(3'b001, 2'b01, 8'h06, 2'b00, 0, 0, 0, 0);
            repeat (CC) cycle();
            checks++; if (dl_detect_out !== 1'b1) begin errors++; $display("FAIL sat_detect rpt=%0d got=%0h want=1", r, dl_detect_out); end
            checks++; if (dl_rpt_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt rpt=%0d got=%0h want=3", r, dl_rpt_cnt); end
            set_in(3'b000, 2'b00, 8'h00, 2'b00, 0, 0, 0, 1);
            cycle();
        end
        clear_sticky = 1'b0;
    endtask

    task automatic test_async_reset();
        set_in(3'b001, 2'b01, 8'h06, 2'b01, 0, 0, 0, 0);
        cycle();
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++; if (token_out_vec !== 3'b000) begin errors++; $display("FAIL arst_token got=%0h want=0", token_out_vec); end
        checks++; if (dl_rpt_cnt !== 2'd0) begin errors++; $display("FAIL arst_cnt got=%0h want=0", dl_rpt_cnt); end
        checks++; if (dl_dep_snapshot !== 4'b0000) begin errors++; $display("FAIL arst_snap got=%0h want=0", dl_dep_snapshot); end
        checks++; if (out_chan_dep_data !== 4'b0010) begin errors++; $display("FAIL arst_depdata got=%0h want=2", out_chan_dep_data); end
        #1 reset = 1'b0;
        for (int c = 1; c <= CC; c++) begin
            cycle();
            checks++;
            if (dl_detect_out !== (c == CC)) begin
                errors++; $display("FAIL arst_rerun cyc=%0d got=%0h want=%0h", c, dl_detect_out, (c == CC));
            end
        end
        checks++; if (dl_rpt_cnt !== 2'd1) begin errors++; $display("FAIL arst_rerun_cnt got=%0h want=1", dl_rpt_cnt); end
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++; if (dl_detect_out !== 1'b0) begin errors++; $display("FAIL arst_report got=%0h want=0", dl_detect_out); end
        checks++; if (dl_rpt_cnt !== 2'd0) begin errors++; $display("FAIL arst_report_cnt got=%0h want=0", dl_rpt_cnt); end
        #1 reset = 1'b0;
        set_in(3'b000, 2'b00, 8'h00, 2'b00, 0, 0, 0, 0);
        cycle();
    endtask

    task automatic test_random();
        logic [OCN-1:0] pdv;
        logic [ICN*PN-1:0] data;
        for (int n = 0; n < 400; n++) begin
            pdv  = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            data = 8'($urandom);
            if ($urandom_range(0, 4) != 0) data[PID] = 1'b1;
            set_in(pdv, 2'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 3)), data,
                   2'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0);
            cycle();
            checks++; if (dl_detect_out !== m_rep) begin errors++; $display("FAIL rnd_detect n=%0d got=%0h want=%0h", n, dl_detect_out, m_rep); end
            checks++; if (dl_rpt_cnt !== RW'(m_cnt)) begin errors++; $display("FAIL rnd_cnt n=%0d got=%0h want=%0h", n, dl_rpt_cnt, m_cnt); end
            checks++; if (dl_dep_snapshot !== m_snap) begin errors++; $display("FAIL rnd_snap n=%0d got=%0h want=%0h", n, dl_dep_snapshot, m_snap); end
            checks++; if (token_out_vec !== m_tok) begin errors++; $display("FAIL rnd_token n=%0d got=%0h want=%0h", n, token_out_vec, m_tok); end
            checks++; if (out_chan_dep_data !== (m_dep | 4'b0010)) begin errors++; $display("FAIL rnd_depdata n=%0d got=%0h want=%0h", n, out_chan_dep_data, m_dep | 4'b0010); end
            checks++; if (out_chan_dep_vld_vec !== proc_dep_vld_vec) begin errors++; $display("FAIL rnd_vld n=%0d got=%0h want=%0h", n, out_chan_dep_vld_vec, proc_dep_vld_vec); end
        end
    endtask

    initial begin
        test_reset();
        test_confirmed();
        test_clear_rearm();
        test_broken_run();
        test_gating();
        test_token();
        test_saturate();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
